// File: rtl/conv_mac.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac
// Purpose  : Signed multiply-accumulate over KERNEL_SIZE^2 (pixel, weight)
//            pairs per window with saturated, frame-tagged result stream.
//            Optional macro CONV_MAC_RELU_EN clamps negative results to 0.
// Revision : 1.0 - initial release
// ============================================================================
module conv_mac #(
  parameter int WIDTH       = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int CONV_SIZE   = 8,
  parameter int FRAC_BITS   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    win_valid,
  output logic                    win_ready,
  input  logic signed [WIDTH-1:0] win_pixel,
  input  logic signed [WIDTH-1:0] win_weight,
  output logic                    mult_valid,
  input  logic                    mult_ready,
  output logic signed [WIDTH-1:0] mult_data,
  output logic                    mult_last
);

  localparam int c_kk     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int c_frame  = CONV_SIZE * CONV_SIZE;
  localparam int c_acc_w  = 2 * WIDTH + $clog2(c_kk);
  localparam int c_elem_w = (c_kk > 1) ? $clog2(c_kk) : 1;
  localparam int c_win_w  = (c_frame > 1) ? $clog2(c_frame) : 1;

  localparam logic [c_elem_w-1:0] c_elem_last = c_elem_w'(c_kk - 1);
  localparam logic [c_win_w-1:0]  c_win_last  = c_win_w'(c_frame - 1);

  localparam logic signed [c_acc_w-1:0] c_sat_max =
    {{(c_acc_w - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [c_acc_w-1:0] c_sat_min = ~c_sat_max;
  localparam logic signed [WIDTH-1:0]   c_max_w   = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic signed [WIDTH-1:0]   c_min_w   = ~c_max_w;

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [c_elem_w-1:0]         r_elem_cnt;
  logic [c_win_w-1:0]          r_win_cnt;
  logic signed [c_acc_w-1:0]   r_acc;
  logic signed [WIDTH-1:0]     r_data;
  logic                        r_last;

  logic                        w_win_ready;
  logic                        w_mult_valid;
  logic                        w_accept;
  logic                        w_win_done;
  logic                        w_out_hs;
  logic [c_win_w-1:0]          w_win_cnt_inc;
  logic [c_win_w-1:0]          w_win_cnt_cur;
  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [c_acc_w-1:0]   w_prod_ext;
  logic signed [c_acc_w-1:0]   w_acc_nxt;
  logic signed [c_acc_w-1:0]   w_shift;
  logic signed [WIDTH-1:0]     w_sat;
  logic signed [WIDTH-1:0]     w_result;

  // ---------------------------------------------------------------------------
  // Arithmetic: product, accumulate, scale, saturate
  // ---------------------------------------------------------------------------
  always_comb begin
    w_prod     = win_pixel * win_weight;
    w_prod_ext = c_acc_w'(w_prod);
    w_acc_nxt  = (r_elem_cnt == '0) ? w_prod_ext : (r_acc + w_prod_ext);
    w_shift    = w_acc_nxt >>> FRAC_BITS;
    if (w_shift > c_sat_max) begin
      w_sat = c_max_w;
    end else if (w_shift < c_sat_min) begin
      w_sat = c_min_w;
    end else begin
      w_sat = w_shift[WIDTH-1:0];
    end
  end

`ifdef CONV_MAC_RELU_EN
  assign w_result = w_sat[WIDTH-1] ? '0 : w_sat;
`else
  assign w_result = w_sat;
`endif

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_win_ready  = 1'b1;
    w_mult_valid = 1'b0;
    w_out_hs     = 1'b0;
    case (r_state)
      S_ACC: begin
        w_win_ready = 1'b1;
      end
      S_OUT: begin
        w_mult_valid = 1'b1;
        // Input side only advances when the held result is taken.
        w_win_ready  = mult_ready;
        w_out_hs     = mult_ready;
      end
      default: begin
        w_win_ready = 1'b1;
      end
    endcase

    w_accept   = win_valid && w_win_ready;
    w_win_done = w_accept && (r_elem_cnt == c_elem_last);

    if (w_win_done) begin
      w_state_nxt = S_OUT;
    end else if (w_out_hs) begin
      w_state_nxt = S_ACC;
    end else if (r_state != S_OUT) begin
      w_state_nxt = S_ACC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, accumulator and result registers
  // ---------------------------------------------------------------------------
  assign w_win_cnt_inc = (r_win_cnt == c_win_last) ? '0 : (r_win_cnt + 1'b1);
  // A window finishing during an output handshake belongs to the next slot.
  assign w_win_cnt_cur = w_out_hs ? w_win_cnt_inc : r_win_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_elem_cnt <= '0;
      r_win_cnt  <= '0;
      r_acc      <= '0;
      r_data     <= '0;
      r_last     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc      <= w_acc_nxt;
        r_elem_cnt <= (r_elem_cnt == c_elem_last) ? '0 : (r_elem_cnt + 1'b1);
      end
      if (w_out_hs) begin
        r_win_cnt <= w_win_cnt_inc;
      end
      if (w_win_done) begin
        r_data <= w_result;
        r_last <= (w_win_cnt_cur == c_win_last);
      end
    end
  end

  assign win_ready  = w_win_ready;
  assign mult_valid = w_mult_valid;
  assign mult_data  = r_data;
  assign mult_last  = r_last;

endmodule
`default_nettype wire
